// File: rtl/c_ram_port_arbiter.sv
// Single-port RAM arbiter: one write channel and NUM_RD read channels, registered RAM control,
// and read data returned to the issuing channel with a one-hot valid tag.
module c_ram_port_arbiter #(
    parameter int                AW        = 4,
    parameter int                DW        = 32,
    parameter int                NUM_RD    = 2,
    parameter int                RD_LAT    = 1,
    parameter int                WR_OFFSET = 1,
    parameter logic [NUM_RD-1:0] RD_OFFSET = NUM_RD'(1),
    parameter int                RR_EN     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_req,
    input  logic [AW-1:0]        wr_addr,
    output logic                 wr_gnt,
    input  logic [NUM_RD-1:0]    rd_req,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_gnt,
    output logic [AW-1:0]        op_address,
    output logic                 ram_en,
    output logic                 ram_w_or_r,
    input  logic [DW-1:0]        ram_rdata,
    output logic [DW-1:0]        rd_data,
    output logic [NUM_RD-1:0]    rd_valid
);

    localparam int          PW  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int unsigned NRD = NUM_RD;
    localparam int unsigned LAT = RD_LAT;

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     sel_idx;
    logic [PW-1:0]     cand;
    logic              rd_any;
    logic [AW-1:0]     wr_eff;
    logic [AW-1:0]     rd_eff   [NUM_RD];
    // One stage beyond RD_LAT so the tag lines up with the cycle ram_rdata is sampled.
    logic [NUM_RD-1:0] tag_pipe [RD_LAT+1];

    // Subtracting one in AW bits wraps 0 to all-ones.
    assign wr_eff = (WR_OFFSET != 0) ? wr_addr - AW'(1) : wr_addr;

    always_comb begin
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_eff[i] = RD_OFFSET[i] ? rd_addr[i*AW +: AW] - AW'(1) : rd_addr[i*AW +: AW];
        end
    end

    always_comb begin
        wr_gnt  = wr_req && !rst;
        rd_gnt  = '0;
        sel_idx = '0;
        cand    = '0;
        rd_any  = 1'b0;
        if (!rst && !wr_req) begin
            for (int unsigned k = 0; k < NRD; k++) begin
                cand = (RR_EN != 0) ? PW'((32'(rr_ptr) + 32'd1 + k) % NRD) : PW'(k);
                if (!rd_any && rd_req[cand]) begin
                    rd_any  = 1'b1;
                    sel_idx = cand;
                end
            end
            if (rd_any) begin
                rd_gnt[sel_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_en     <= 1'b0;
            ram_w_or_r <= 1'b0;
            op_address <= '0;
            rr_ptr     <= PW'(NUM_RD - 1);
            rd_data    <= '0;
            rd_valid   <= '0;
            for (int unsigned j = 0; j <= LAT; j++) begin
                tag_pipe[j] <= '0;
            end
        end else begin
            ram_en <= wr_gnt || rd_any;
            if (wr_gnt) begin
                ram_w_or_r <= 1'b1;
                op_address <= wr_eff;
            end else if (rd_any) begin
                ram_w_or_r <= 1'b0;
                op_address <= rd_eff[sel_idx];
                rr_ptr     <= sel_idx;
            end
            tag_pipe[0] <= rd_gnt;
            for (int unsigned j = 1; j <= LAT; j++) begin
                tag_pipe[j] <= tag_pipe[j-1];
            end
            rd_valid <= tag_pipe[RD_LAT];
            if (|tag_pipe[RD_LAT]) begin
                rd_data <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_c_ram_port_arbiter.sv
// Bench for c_ram_port_arbiter: two configurations driven by shared stimulus, checked each cycle
// against a transaction-level model with due-time return slots, plus directed literal checks.
module tb_c_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req;
    logic [3:0]  wr_addr;
    logic [1:0]  rd_req;
    logic [7:0]  rd_addr;

    logic        wr_gnt_o   [2];
    logic [1:0]  rd_gnt_o   [2];
    logic [3:0]  op_o       [2];
    logic        en_o       [2];
    logic        wor_o      [2];
    logic [31:0] rdata_i    [2];
    logic [31:0] rd_data_o  [2];
    logic [1:0]  rd_valid_o [2];
    logic [31:0] rp0        [2];
    logic [31:0] rp1        [2];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int ram_cyc  = 0;
    bit ram_fixed = 1'b1;
    bit check_en  = 1'b0;

    // model state
    logic        m_en    [2];
    logic        m_wr    [2];
    logic [3:0]  m_addr  [2];
    logic [1:0]  m_valid [2];
    logic [31:0] m_data  [2];
    int          m_last  [2] = '{1, 1};
    bit          rv      [2][8];
    int          rch     [2][8];
    logic [31:0] rdt     [2][8];
    int mk, mch, slot;
    int ck, cch;

    always #5 clk = ~clk;

    c_ram_port_arbiter #(.AW(4), .DW(32), .NUM_RD(2), .RD_LAT(1), .WR_OFFSET(1),
                         .RD_OFFSET(2'b01), .RR_EN(0)) u_dut0 (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt_o[0]),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt_o[0]), .op_address(op_o[0]),
        .ram_en(en_o[0]), .ram_w_or_r(wor_o[0]), .ram_rdata(rdata_i[0]),
        .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]));

    c_ram_port_arbiter #(.AW(4), .DW(32), .NUM_RD(2), .RD_LAT(2), .WR_OFFSET(0),
                         .RD_OFFSET(2'b10), .RR_EN(1)) u_dut1 (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt_o[1]),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt_o[1]), .op_address(op_o[1]),
        .ram_en(en_o[1]), .ram_w_or_r(wor_o[1]), .ram_rdata(rdata_i[1]),
        .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]));

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic bit woff(input int i);
        return (i == 0);
    endfunction

    function automatic bit roff(input int i, input int ch);
        return (i == 0) ? (ch == 0) : (ch == 1);
    endfunction

    function automatic logic [3:0] offs(input logic [3:0] a, input bit en);
        if (!en) return a;
        return (a == 4'h0) ? 4'hF : a - 4'd1;
    endfunction

    function automatic logic [31:0] ramf(input logic [3:0] a, input int c, input bit fixed);
        logic [31:0] cv;
        cv = c;
        return fixed ? 32'hA5A5_0001 : {16'hA5A5, a, cv[11:0]};
    endfunction

    // Write beats reads; fixed mode takes lowest index, RR mode the first requester after the last winner.
    task automatic model_grant(input int i, input logic r, input logic w, input logic [1:0] rq,
                               input int last, output int kind, output int ch);
        kind = 0;
        ch   = 0;
        if (r || (!w && rq == 2'b00)) return;
        if (w) begin
            kind = 1;
            return;
        end
        kind = 2;
        if (i == 1) begin
            ch = (last + 1) % 2;
            if (((rq >> ch) & 2'b01) == 2'b00) ch = (ch + 1) % 2;
        end else begin
            ch = rq[0] ? 0 : 1;
        end
    endtask

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d] at cycle %0d: got %h expected %h", name, inst, cyc, act, exp);
    endtask

    assign rdata_i[0] = rp0[0];
    assign rdata_i[1] = rp1[1];

    // RAM: read data appears RD_LAT cycles after the enable cycle, junk otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            rp0[i] <= (en_o[i] === 1'b1 && wor_o[i] === 1'b0) ? ramf(op_o[i], ram_cyc, ram_fixed)
                                                               : $urandom;
            rp1[i] <= rp0[i];
        end
        ram_cyc <= ram_cyc + 1;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            model_grant(i, rst, wr_req, rd_req, m_last[i], mk, mch);
            if (rst) begin
                m_en[i]    = 1'b0;
                m_wr[i]    = 1'b0;
                m_addr[i]  = 4'h0;
                m_valid[i] = 2'b00;
                m_data[i]  = 32'h0;
                m_last[i]  = 1;
                for (int s = 0; s < 8; s++) rv[i][s] = 1'b0;
            end else begin
                m_en[i] = (mk != 0);
                if (mk == 1) begin
                    m_wr[i]   = 1'b1;
                    m_addr[i] = offs(wr_addr, woff(i));
                end else if (mk == 2) begin
                    m_wr[i]   = 1'b0;
                    m_addr[i] = offs((mch == 0) ? rd_addr[3:0] : rd_addr[7:4], roff(i, mch));
                    m_last[i] = mch;
                    slot = (cyc + 1 + lat(i)) % 8;
                    rv[i][slot]  = 1'b1;
                    rch[i][slot] = mch;
                    rdt[i][slot] = ramf(m_addr[i], cyc + 1, ram_fixed);
                end
                slot = cyc % 8;
                if (rv[i][slot]) begin
                    m_valid[i]  = (rch[i][slot] == 0) ? 2'b01 : 2'b10;
                    m_data[i]   = rdt[i][slot];
                    rv[i][slot] = 1'b0;
                end else begin
                    m_valid[i] = 2'b00;
                end
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                model_grant(i, rst, wr_req, rd_req, m_last[i], ck, cch);
                chk("wr_gnt", i, 32'(wr_gnt_o[i]), 32'(ck == 1));
                chk("rd_gnt", i, 32'(rd_gnt_o[i]), (ck == 2) ? 32'(1 << cch) : 32'h0);
                chk("ram_en", i, 32'(en_o[i]), 32'(m_en[i]));
                chk("ram_w_or_r", i, 32'(wor_o[i]), 32'(m_wr[i]));
                chk("op_address", i, 32'(op_o[i]), 32'(m_addr[i]));
                chk("rd_valid", i, 32'(rd_valid_o[i]), 32'(m_valid[i]));
                chk("rd_data", i, rd_data_o[i], m_data[i]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_req = 1'b1; wr_addr = 4'h0; rd_req = 2'b11; rd_addr = 8'h00;
        step();
        check_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_wr_gnt", 0, 32'(wr_gnt_o[0]), 32'h0);
            chk("rst_rd_gnt", 1, 32'(rd_gnt_o[1]), 32'h0);
        end
        step();
        rst = 1'b0; wr_req = 1'b0; rd_req = 2'b00;
        @(negedge clk);
        chk("post_rst_en", 0, 32'(en_o[0]), 32'h0);
        chk("post_rst_addr", 0, 32'(op_o[0]), 32'h0);
        chk("post_rst_valid", 1, 32'(rd_valid_o[1]), 32'h0);

        // write to address 0 wraps to 0xF
        step();
        wr_req = 1'b1; wr_addr = 4'h0;
        @(negedge clk);
        chk("t2_wr_gnt", 0, 32'(wr_gnt_o[0]), 32'h1);
        step();
        wr_req = 1'b0;
        @(negedge clk);
        chk("t2_en", 0, 32'(en_o[0]), 32'h1);
        chk("t2_wor", 0, 32'(wor_o[0]), 32'h1);
        chk("t2_addr", 0, 32'(op_o[0]), 32'hF);

        // write, then rd0, then rd1 in fixed priority
        step();
        wr_req = 1'b1; wr_addr = 4'h7; rd_req = 2'b11; rd_addr = 8'h33;
        @(negedge clk);
        chk("t3_wr_gnt", 0, 32'(wr_gnt_o[0]), 32'h1);
        chk("t3_rd_gnt_n", 0, 32'(rd_gnt_o[0]), 32'h0);
        step();
        wr_req = 1'b0;
        @(negedge clk);
        chk("t3_rd_gnt_n1", 0, 32'(rd_gnt_o[0]), 32'h1);
        chk("t3_wor_n1", 0, 32'(wor_o[0]), 32'h1);
        chk("t3_addr_n1", 0, 32'(op_o[0]), 32'h6);
        step();
        rd_req = 2'b10;
        @(negedge clk);
        chk("t3_rd_gnt_n2", 0, 32'(rd_gnt_o[0]), 32'h2);
        chk("t3_wor_n2", 0, 32'(wor_o[0]), 32'h0);
        chk("t3_addr_n2", 0, 32'(op_o[0]), 32'h2);
        step();
        rd_req = 2'b00;
        @(negedge clk);
        chk("t3_wor_n3", 0, 32'(wor_o[0]), 32'h0);
        chk("t3_addr_n3", 0, 32'(op_o[0]), 32'h3);

        // both readers held: RR alternates, fixed always ch0
        step();
        rd_req = 2'b11;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t4_fixed", 0, 32'(rd_gnt_o[0]), 32'h1);
            chk("t4_rr", 1, 32'(rd_gnt_o[1]), (k % 2 == 0) ? 32'h1 : 32'h2);
            step();
        end
        rd_req = 2'b00;
        repeat (4) step();

        // RD_LAT=2 return on channel 1
        rd_req = 2'b10; rd_addr = 8'h50;
        @(negedge clk);
        chk("t5_rd_gnt", 1, 32'(rd_gnt_o[1]), 32'h2);
        step();
        rd_req = 2'b00;
        @(negedge clk);
        chk("t5_addr", 1, 32'(op_o[1]), 32'h4);
        step();
        step();
        @(negedge clk);
        chk("t5_valid_early", 1, 32'(rd_valid_o[1]), 32'h0);
        step();
        @(negedge clk);
        chk("t5_valid", 1, 32'(rd_valid_o[1]), 32'h2);
        chk("t5_data", 1, rd_data_o[1], 32'hA5A5_0001);

        // reset right after a read grant discards the read
        repeat (3) step();
        rd_req = 2'b01; rd_addr = 8'h09;
        @(negedge clk);
        chk("t6_rd_gnt", 0, 32'(rd_gnt_o[0]), 32'h1);
        step();
        rst = 1'b1; wr_req = 1'b1; rd_req = 2'b11;
        @(negedge clk);
        chk("t6_rst_wr_gnt", 0, 32'(wr_gnt_o[0]), 32'h0);
        chk("t6_rst_rd_gnt", 1, 32'(rd_gnt_o[1]), 32'h0);
        step();
        rst = 1'b0; wr_req = 1'b0; rd_req = 2'b00;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("t6_no_valid", 0, 32'(rd_valid_o[0]), 32'h0);
            chk("t6_no_valid", 1, 32'(rd_valid_o[1]), 32'h0);
            step();
        end
        rd_req = 2'b01;
        step();
        rd_req = 2'b00;
        step();
        step();
        @(negedge clk);
        chk("t6_valid", 0, 32'(rd_valid_o[0]), 32'h1);
        chk("t6_data", 0, rd_data_o[0], 32'hA5A5_0001);
        step();
        @(negedge clk);
        chk("t6_valid", 1, 32'(rd_valid_o[1]), 32'h1);

        repeat (6) step();
        ram_fixed = 1'b0;
        repeat (6) step();

        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 63) == 0);
            wr_req  = ($urandom_range(0, 3) == 0);
            wr_addr = 4'($urandom);
            rd_req  = 2'($urandom);
            rd_addr = 8'($urandom);
            step();
        end
        rst = 1'b0; wr_req = 1'b0; rd_req = 2'b00;
        repeat (8) step();
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
